// File: rtl/sqrt_fx.sv
// Iterative unsigned fixed-point square root (radix-2 digit recurrence) with remainder, exact flag and optional round-to-nearest.
// Latency: RBITS cycles from the accepting edge to oValid; one root bit is resolved per clock, initiation interval RBITS+2.
// Backpressure: result/rem/exact are held while oValid && !oReady; iReady stays low until the result has been taken.
module sqrt_fx #(
    parameter int NBITS = 8,
    parameter int FRAC  = 4,
    localparam int NPAD  = NBITS + (NBITS % 2),
    localparam int RBITS = NPAD / 2 + FRAC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] A,
    input  logic             round,
    input  logic             iValid,
    output logic             iReady,
    input  logic             oReady,
    output logic             oValid,
    output logic [RBITS-1:0] result,
    output logic [RBITS:0]   rem,
    output logic             exact
);

    // Radicand register holds 2*RBITS bits, consumed two bits per iteration.
    localparam int XW = 2 * RBITS;
    // Partial remainder / trial value width; wide enough for R' = 4R+3 on the last step.
    localparam int WW = RBITS + 2;
    // Iteration counter width; at least one bit even for a single-iteration root.
    localparam int CW = (RBITS > 1) ? $clog2(RBITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XW-1:0]   x_q;      // remaining radicand bits, next pair at the top
    logic            rnd_q;    // rounding mode captured with the operand
    logic [RBITS-1:0] q_q;     // partial root
    logic [WW-1:0]   r_q;      // partial remainder
    logic [CW-1:0]   cnt;      // iterations left after the current one

    logic [WW-1:0]    r_sh;
    logic [WW-1:0]    t_val;
    logic             ge;
    logic [WW-1:0]    r_nxt;
    logic [RBITS-1:0] q_nxt;
    logic             q_inc;
    logic [RBITS-1:0] res_nxt;

    // One recurrence step plus the rounding decision that applies when this step is the last.
    always_comb begin
        // Bring down the next radicand bit-pair; the dropped top bits of r_q are always zero.
        r_sh  = WW'({r_q, x_q[XW-1 -: 2]});
        // Trial subtrahend 4Q+1.
        t_val = {q_q, 2'b01};
        ge    = (r_sh >= t_val);
        r_nxt = ge ? (r_sh - t_val) : r_sh;
        q_nxt = (q_q << 1) | RBITS'(ge);
        // Round up when the fractional part of the root exceeds one half, i.e. R > Q;
        // an all-ones root cannot be incremented, so it saturates.
        q_inc   = rnd_q && (r_nxt > WW'(q_nxt)) && !(&q_nxt);
        res_nxt = q_inc ? (q_nxt + RBITS'(1)) : q_nxt;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            iReady <= 1'b0;
            oValid <= 1'b0;
            result <= '0;
            rem    <= '0;
            exact  <= 1'b0;
            x_q    <= '0;
            rnd_q  <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    iReady <= 1'b1;
                    if (iValid && iReady) begin
                        x_q    <= XW'(A) << (2 * FRAC);
                        rnd_q  <= round;
                        q_q    <= '0;
                        r_q    <= '0;
                        cnt    <= CW'(RBITS - 1);
                        iReady <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    x_q <= x_q << 2;
                    q_q <= q_nxt;
                    r_q <= r_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        result <= res_nxt;
                        rem    <= r_nxt[RBITS:0];
                        exact  <= (r_nxt == '0);
                        oValid <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (oReady) begin
                        oValid <= 1'b0;
                        iReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_fx.sv
// Bench for sqrt_fx: three configurations (8/4, 8/0, 7/3) driven with directed vectors and an exhaustive sweep.
// Expected results come from hand-computed constants and an integer square-root model; one negedge process compares.
// Inputs are driven 1 time unit after the rising edge; outputs are observed on the falling edge.
module tb_sqrt_fx;

    typedef struct {
        int res;
        int rem;
        int ex;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // Configuration A: NBITS=8, FRAC=4 (RBITS=8)
    logic [7:0] a_A;
    logic       a_round, a_iv, a_ir, a_or, a_ov, a_ex;
    logic [7:0] a_res;
    logic [8:0] a_rem;
    // Configuration B: NBITS=8, FRAC=0 (RBITS=4)
    logic [7:0] b_A;
    logic       b_round, b_iv, b_ir, b_or, b_ov, b_ex;
    logic [3:0] b_res;
    logic [4:0] b_rem;
    // Configuration C: NBITS=7, FRAC=3 (RBITS=7)
    logic [6:0] c_A;
    logic       c_round, c_iv, c_ir, c_or, c_ov, c_ex;
    logic [6:0] c_res;
    logic [7:0] c_rem;

    sqrt_fx #(.NBITS(8), .FRAC(4)) dut_a (
        .clock(clock), .reset(reset), .A(a_A), .round(a_round), .iValid(a_iv), .iReady(a_ir),
        .oReady(a_or), .oValid(a_ov), .result(a_res), .rem(a_rem), .exact(a_ex)
    );
    sqrt_fx #(.NBITS(8), .FRAC(0)) dut_b (
        .clock(clock), .reset(reset), .A(b_A), .round(b_round), .iValid(b_iv), .iReady(b_ir),
        .oReady(b_or), .oValid(b_ov), .result(b_res), .rem(b_rem), .exact(b_ex)
    );
    sqrt_fx #(.NBITS(7), .FRAC(3)) dut_c (
        .clock(clock), .reset(reset), .A(c_A), .round(c_round), .iValid(c_iv), .iReady(c_ir),
        .oReady(c_or), .oValid(c_ov), .result(c_res), .rem(c_rem), .exact(c_ex)
    );

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic cmp(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int res, input int rem, input int ex);
        exp_t e;
        e.res = res;
        e.rem = rem;
        e.ex  = ex;
        return e;
    endfunction

    // Reference: plain integer square root of A * 4^FRAC, with optional saturating round-to-nearest.
    function automatic exp_t model(input int a, input int frac, input int nbits, input bit rnd);
        exp_t   e;
        longint x, r, top, rm;
        int     rbits;
        rbits = (nbits + nbits % 2) / 2 + frac;
        x     = longint'(a) * (longint'(1) << (2 * frac));
        r     = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        rm    = x - r * r;
        top   = (longint'(1) << rbits) - 1;
        e.rem = int'(rm);
        e.ex  = (rm == 0) ? 1 : 0;
        e.res = (rnd && rm > r && r < top) ? int'(r + 1) : int'(r);
        return e;
    endfunction

    function automatic bit ir_of(input int w);
        case (w)
            0:       return a_ir;
            1:       return b_ir;
            default: return c_ir;
        endcase
    endfunction

    task automatic set_in(input int w, input bit v, input int a, input bit r);
        case (w)
            0:       begin a_iv = v; a_A = 8'(a); a_round = r; end
            1:       begin b_iv = v; b_A = 8'(a); b_round = r; end
            default: begin c_iv = v; c_A = 7'(a); c_round = r; end
        endcase
    endtask

    // Called just after a rising edge; returns just after the accepting edge with scrambled inputs.
    task automatic send(input int w, input int a, input bit r);
        int n;
        n = 0;
        while (!ir_of(w) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        cmp("iready_wait", int'(ir_of(w)), 1);
        set_in(w, 1'b1, a, r);
        @(posedge clock); #1;
        set_in(w, 1'b0, int'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        cmp("drain", qa.size() + qb.size() + qc.size(), 0);
    endtask

    // Single compare process: every valid output is checked against the head of its expectation queue.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (a_ov === 1'b1) begin
                if (qa.size() == 0) cmp("a_unexpected_ovalid", int'(a_ov), 0);
                else begin
                    cmp("a_result", int'(a_res), qa[0].res);
                    cmp("a_rem", int'(a_rem), qa[0].rem);
                    cmp("a_exact", int'(a_ex), qa[0].ex);
                    if (a_or) qa.delete(0);
                end
                cmp("a_iready_with_ovalid", int'(a_ir), 0);
            end
            if (b_ov === 1'b1) begin
                if (qb.size() == 0) cmp("b_unexpected_ovalid", int'(b_ov), 0);
                else begin
                    cmp("b_result", int'(b_res), qb[0].res);
                    cmp("b_rem", int'(b_rem), qb[0].rem);
                    cmp("b_exact", int'(b_ex), qb[0].ex);
                    if (b_or) qb.delete(0);
                end
                cmp("b_iready_with_ovalid", int'(b_ir), 0);
            end
            if (c_ov === 1'b1) begin
                if (qc.size() == 0) cmp("c_unexpected_ovalid", int'(c_ov), 0);
                else begin
                    cmp("c_result", int'(c_res), qc[0].res);
                    cmp("c_rem", int'(c_rem), qc[0].rem);
                    cmp("c_exact", int'(c_ex), qc[0].ex);
                    if (c_or) qc.delete(0);
                end
                cmp("c_iready_with_ovalid", int'(c_ir), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lat, n, acc, nov;
        int   ov_at[3];

        reset = 1'b1;
        set_in(0, 1'b0, 0, 1'b0);
        set_in(1, 1'b0, 0, 1'b0);
        set_in(2, 1'b0, 0, 1'b0);
        a_or = 1'b1;
        b_or = 1'b1;
        c_or = 1'b1;
        ov_at = '{0, 0, 0};

        // Pin the reference model to hand-computed values.
        e = model(2, 4, 8, 1'b0);   cmp("model_2_res", e.res, 22);  cmp("model_2_rem", e.rem, 28);
        e = model(2, 4, 8, 1'b1);   cmp("model_2_rnd", e.res, 23);
        e = model(144, 4, 8, 1'b0); cmp("model_144_res", e.res, 192); cmp("model_144_ex", e.ex, 1);
        e = model(255, 0, 8, 1'b1); cmp("model_255_sat", e.res, 15); cmp("model_255_rem", e.rem, 30);
        e = model(127, 3, 7, 1'b1); cmp("model_127_res", e.res, 90); cmp("model_127_rem", e.rem, 28);

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        cmp("rst_a_iready", int'(a_ir), 0);
        cmp("rst_a_ovalid", int'(a_ov), 0);
        cmp("rst_a_result", int'(a_res), 0);
        cmp("rst_a_rem", int'(a_rem), 0);
        cmp("rst_a_exact", int'(a_ex), 0);
        cmp("rst_b_ovalid", int'(b_ov), 0);
        cmp("rst_c_ovalid", int'(c_ov), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        cmp("idle_a_iready", int'(a_ir), 1);

        // Directed: A=2 truncate, with latency measurement from the accepting edge.
        qa.push_back(mk(8'h16, 28, 0));
        send(0, 2, 1'b0);
        lat = 0;
        while (!a_ov && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        cmp("a_latency", lat, 8);
        drain();

        // Directed: rounding, exact square, zero.
        qa.push_back(mk(23, 28, 0));  send(0, 2, 1'b1);
        qa.push_back(mk(192, 0, 1));  send(0, 144, 1'b0);
        qa.push_back(mk(192, 0, 1));  send(0, 144, 1'b1);
        qa.push_back(mk(0, 0, 1));    send(0, 0, 1'b1);
        qa.push_back(mk(255, 255, 0)); send(0, 255, 1'b1);
        drain();

        // FRAC=0: rounding saturation and small cases.
        qb.push_back(mk(15, 30, 0)); send(1, 255, 1'b1);
        qb.push_back(mk(15, 30, 0)); send(1, 255, 1'b0);
        qb.push_back(mk(4, 0, 1));   send(1, 16, 1'b1);
        qb.push_back(mk(2, 2, 0));   send(1, 3, 1'b1);
        qb.push_back(mk(1, 0, 1));   send(1, 1, 1'b1);
        drain();

        // Backpressure: result held for 20 cycles, iValid pulses ignored.
        a_or = 1'b0;
        qa.push_back(mk(48, 0, 1));
        send(0, 9, 1'b0);
        n = 0;
        while (!a_ov && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        cmp("bp_ovalid_seen", int'(a_ov), 1);
        for (int k = 0; k < 20; k++) begin
            set_in(0, 1'b1, k * 7 + 1, k[0]);
            @(posedge clock); #1;
            cmp("bp_result_held", int'(a_res), 48);
            cmp("bp_iready_low", int'(a_ir), 0);
        end
        set_in(0, 1'b0, 0, 1'b0);
        a_or = 1'b1;
        @(posedge clock); #1;
        cmp("bp_ovalid_fall", int'(a_ov), 0);
        cmp("bp_iready_rise", int'(a_ir), 1);
        drain();

        // Back-to-back operands with oReady high: initiation interval RBITS+2 = 10.
        repeat (3) qa.push_back(mk(160, 0, 1));
        set_in(0, 1'b1, 100, 1'b0);
        acc = 0;
        nov = 0;
        for (int k = 0; k < 80 && nov < 3; k++) begin
            if (a_iv && a_ir) acc++;
            @(posedge clock); #1;
            if (acc == 3) set_in(0, 1'b0, 0, 1'b0);
            if (a_ov) begin
                ov_at[nov] = k;
                nov++;
            end
        end
        set_in(0, 1'b0, 0, 1'b0);
        cmp("ii_count", nov, 3);
        cmp("ii_first", ov_at[1] - ov_at[0], 10);
        cmp("ii_second", ov_at[2] - ov_at[1], 10);
        drain();

        // Reset on the third iteration edge aborts silently.
        send(0, 77, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        cmp("abort_ovalid", int'(a_ov), 0);
        cmp("abort_iready", int'(a_ir), 0);
        cmp("abort_result", int'(a_res), 0);
        cmp("abort_rem", int'(a_rem), 0);
        cmp("abort_exact", int'(a_ex), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        cmp("abort_iready_back", int'(a_ir), 1);
        qa.push_back(mk(255, 255, 0));
        send(0, 255, 1'b0);
        drain();

        // Odd width NBITS=7, FRAC=3: exhaustive operands, both rounding modes.
        for (int a = 0; a < 128; a++) begin
            for (int r = 0; r < 2; r++) begin
                qc.push_back(model(a, 3, 7, r[0]));
                send(2, a, r[0]);
            end
        end
        drain();

        cmp("qa_empty", qa.size(), 0);
        cmp("qc_empty", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
